// File: rtl/operand_stack_pkg.sv
// Shared definitions for the wasm CPU operand stack.
// Holds the value type tags, the stack operation codes and the trap codes.
// The trap codes use the same encoding as the CPU trap port.
package operand_stack_pkg;

    // Value type tags
    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;
    localparam logic [1:0] TYPE_F32 = 2'd2;
    localparam logic [1:0] TYPE_F64 = 2'd3;

    // Stack operation codes; 6 and 7 decode as NOP
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_DROP   = 3'd2;
    localparam logic [2:0] OP_UNARY  = 3'd3;
    localparam logic [2:0] OP_BINARY = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    // Trap codes, shared with the CPU trap output
    localparam logic [3:0] TRAP_NONE            = 4'd0;
    localparam logic [3:0] TRAP_STACK_OVERFLOW  = 4'd1;
    localparam logic [3:0] TRAP_STACK_UNDERFLOW = 4'd2;
    localparam logic [3:0] TRAP_TYPE_MISMATCH   = 4'd3;

endpackage

// File: rtl/operand_stack_ram.sv
// Storage array for the operand stack.
// One synchronous write port and one asynchronous read port.
// Ports:
//   clk     - system clock, rising edge
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - tagged word written ({type, value})
//   rd_addr - asynchronous read address
//   rd_data - tagged word at rd_addr
// The contents are not reset; the control logic never exposes an
// entry that has not been written since the last reset or clear.
module operand_stack_ram #(
    parameter int WIDTH = 66,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [2**ADDR];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/operand_stack.sv
// Typed operand stack for the wasm CPU core.
// Applies one operation per cycle (push, drop, unary replace, binary
// collapse, clear) and exposes the two top entries to the ALU.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   op          - operation code (see operand_stack_pkg)
//   data        - value written by PUSH/UNARY/BINARY
//   data_type   - type tag written with data
//   check_type  - operand type required by UNARY/BINARY
//   top/top_type       - entry count-1 (0 when empty)
//   second/second_type - entry count-2 (0 when count<2)
//   count       - number of valid entries
//   empty/full  - count==0 / count==depth
//   trap        - sticky trap code, 0 = none
// top and second are kept in registers; the RAM is only read for the
// entry that becomes "second" after a DROP or BINARY (entry count-3).
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STACK_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            data_type,
    input  logic [1:0]            check_type,
    output logic [DATA_WIDTH-1:0] top,
    output logic [1:0]            top_type,
    output logic [DATA_WIDTH-1:0] second,
    output logic [1:0]            second_type,
    output logic [STACK_ADDR:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic [3:0]            trap
);

    localparam logic [STACK_ADDR:0] DEPTH_C = {1'b1, {STACK_ADDR{1'b0}}};
    localparam logic [STACK_ADDR:0] ONE_C   = {{STACK_ADDR{1'b0}}, 1'b1};
    localparam logic [STACK_ADDR:0] TWO_C   = ONE_C + ONE_C;
    localparam logic [STACK_ADDR:0] THREE_C = TWO_C + ONE_C;

    logic [STACK_ADDR:0]   count_r, count_nxt_s;
    logic [3:0]            trap_r, trap_nxt_s;
    logic [DATA_WIDTH-1:0] top_r, top_nxt_s, second_r, second_nxt_s;
    logic [1:0]            top_type_r, top_type_nxt_s;
    logic [1:0]            second_type_r, second_type_nxt_s;
    logic                  empty_r, full_r;

    logic                  wr_en_s;
    logic [STACK_ADDR:0]   wr_ptr_s;
    logic [STACK_ADDR:0]   cnt_m1_s, cnt_m2_s, cnt_m3_s;
    logic [DATA_WIDTH+1:0] rd_data_s;

    assign cnt_m1_s = count_r - ONE_C;
    assign cnt_m2_s = count_r - TWO_C;
    assign cnt_m3_s = count_r - THREE_C;

    operand_stack_ram #(
        .WIDTH (DATA_WIDTH + 2),
        .ADDR  (STACK_ADDR)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_s[STACK_ADDR-1:0]),
        .wr_data ({data_type, data}),
        .rd_addr (cnt_m3_s[STACK_ADDR-1:0]),
        .rd_data (rd_data_s)
    );

    // Next-state decode: storage write, count, trap and new top/second
    always_comb begin
        count_nxt_s       = count_r;
        trap_nxt_s        = trap_r;
        top_nxt_s         = top_r;
        top_type_nxt_s    = top_type_r;
        second_nxt_s      = second_r;
        second_type_nxt_s = second_type_r;
        wr_en_s           = 1'b0;
        wr_ptr_s          = count_r;

        if (op == OP_CLEAR) begin
            count_nxt_s = '0;
            trap_nxt_s  = TRAP_NONE;
        end else if (trap_r != TRAP_NONE) begin
            // Sticky trap: everything holds until CLEAR
            count_nxt_s = count_r;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (count_r == DEPTH_C) begin
                        trap_nxt_s = TRAP_STACK_OVERFLOW;
                    end else begin
                        wr_en_s           = 1'b1;
                        wr_ptr_s          = count_r;
                        count_nxt_s       = count_r + ONE_C;
                        top_nxt_s         = data;
                        top_type_nxt_s    = data_type;
                        second_nxt_s      = top_r;
                        second_type_nxt_s = top_type_r;
                    end
                end
                OP_DROP: begin
                    if (count_r == '0) begin
                        trap_nxt_s = TRAP_STACK_UNDERFLOW;
                    end else begin
                        count_nxt_s                       = cnt_m1_s;
                        top_nxt_s                         = second_r;
                        top_type_nxt_s                    = second_type_r;
                        {second_type_nxt_s, second_nxt_s} = rd_data_s;
                    end
                end
                OP_UNARY: begin
                    if (count_r == '0) begin
                        trap_nxt_s = TRAP_STACK_UNDERFLOW;
                    end else if (top_type_r != check_type) begin
                        trap_nxt_s = TRAP_TYPE_MISMATCH;
                    end else begin
                        wr_en_s        = 1'b1;
                        wr_ptr_s       = cnt_m1_s;
                        top_nxt_s      = data;
                        top_type_nxt_s = data_type;
                    end
                end
                OP_BINARY: begin
                    // Underflow is checked first so it wins over a mismatch
                    if (count_r < TWO_C) begin
                        trap_nxt_s = TRAP_STACK_UNDERFLOW;
                    end else if ((top_type_r != check_type) ||
                                 (second_type_r != check_type)) begin
                        trap_nxt_s = TRAP_TYPE_MISMATCH;
                    end else begin
                        wr_en_s                           = 1'b1;
                        wr_ptr_s                          = cnt_m2_s;
                        count_nxt_s                       = cnt_m1_s;
                        top_nxt_s                         = data;
                        top_type_nxt_s                    = data_type;
                        {second_type_nxt_s, second_nxt_s} = rd_data_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end

        // Entries at or above the new count read as zero
        if (count_nxt_s == '0) begin
            top_nxt_s      = '0;
            top_type_nxt_s = 2'd0;
        end else begin
            top_type_nxt_s = top_type_nxt_s;
        end
        if (count_nxt_s < TWO_C) begin
            second_nxt_s      = '0;
            second_type_nxt_s = 2'd0;
        end else begin
            second_type_nxt_s = second_type_nxt_s;
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r       <= '0;
            trap_r        <= TRAP_NONE;
            top_r         <= '0;
            top_type_r    <= 2'd0;
            second_r      <= '0;
            second_type_r <= 2'd0;
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
        end else begin
            count_r       <= count_nxt_s;
            trap_r        <= trap_nxt_s;
            top_r         <= top_nxt_s;
            top_type_r    <= top_type_nxt_s;
            second_r      <= second_nxt_s;
            second_type_r <= second_type_nxt_s;
            empty_r       <= (count_nxt_s == '0);
            full_r        <= (count_nxt_s == DEPTH_C);
        end
    end

    assign count       = count_r;
    assign trap        = trap_r;
    assign top         = top_r;
    assign top_type    = top_type_r;
    assign second      = second_r;
    assign second_type = second_type_r;
    assign empty       = empty_r;
    assign full        = full_r;

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack (DATA_WIDTH=64, STACK_ADDR=4).
// A reference model pushes the expected output vector to a scoreboard
// queue for every op driven; each test pops and compares after the edge.
module tb_operand_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] data = 64'd0;
    logic [1:0]  data_type = 2'd0;
    logic [1:0]  check_type = 2'd0;
    logic [63:0] top, second;
    logic [1:0]  top_type, second_type;
    logic [4:0]  count;
    logic        empty, full;
    logic [3:0]  trap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [65:0]  mem_m [16];
    int           cnt_m  = 0;
    logic [3:0]   trap_m = 4'd0;
    logic [142:0] sb [$];
    logic [142:0] exp_v;
    wire  [142:0] obs_v = {count, top_type, top, second_type, second, empty, full, trap};

    operand_stack #(.DATA_WIDTH(64), .STACK_ADDR(4)) dut (
        .clk(clk), .reset(reset), .op(op), .data(data), .data_type(data_type),
        .check_type(check_type), .top(top), .top_type(top_type), .second(second),
        .second_type(second_type), .count(count), .empty(empty), .full(full), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [142:0] model_exp();
        logic [65:0] t, s;
        t = (cnt_m >= 1) ? mem_m[cnt_m-1] : 66'd0;
        s = (cnt_m >= 2) ? mem_m[cnt_m-2] : 66'd0;
        return {5'(cnt_m), t, s, (cnt_m == 0), (cnt_m == 16), trap_m};
    endfunction

    task automatic model_step(input logic [2:0] o, input logic [63:0] d,
                              input logic [1:0] dt, input logic [1:0] ct);
        if (o == 3'd5) begin
            cnt_m = 0; trap_m = 4'd0;
        end else if (trap_m == 4'd0) begin
            case (o)
                3'd1: if (cnt_m == 16) trap_m = 4'd1;
                      else begin mem_m[cnt_m] = {dt, d}; cnt_m++; end
                3'd2: if (cnt_m == 0) trap_m = 4'd2; else cnt_m--;
                3'd3: if (cnt_m == 0) trap_m = 4'd2;
                      else if (mem_m[cnt_m-1][65:64] != ct) trap_m = 4'd3;
                      else mem_m[cnt_m-1] = {dt, d};
                3'd4: if (cnt_m < 2) trap_m = 4'd2;
                      else if (mem_m[cnt_m-1][65:64] != ct || mem_m[cnt_m-2][65:64] != ct) trap_m = 4'd3;
                      else begin mem_m[cnt_m-2] = {dt, d}; cnt_m--; end
                default: ;
            endcase
        end
        sb.push_back(model_exp());
    endtask

    // Drive one op at the falling edge, let it be sampled, return #1 after the edge
    task automatic do_op(input logic [2:0] o, input logic [63:0] d,
                         input logic [1:0] dt, input logic [1:0] ct);
        @(negedge clk);
        op = o; data = d; data_type = dt; check_type = ct;
        model_step(o, d, dt, ct);
        @(posedge clk);
        #1;
        op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_checks++;
        if (obs_v !== model_exp()) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", obs_v, model_exp());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add();
        logic [2:0]  o_t  [3] = '{3'd1, 3'd1, 3'd4};
        logic [63:0] d_t  [3] = '{64'd1, 64'd2, 64'd3};
        for (int i = 0; i < 3; i++) begin
            do_op(o_t[i], d_t[i], 2'd1, 2'd1);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL add_step%0d got %h want %h", i, obs_v, exp_v);
            end
            if (i == 1) begin
                n_checks++;
                if (top !== 64'd2 || second !== 64'd1) begin
                    n_fail++;
                    $display("FAIL add_two_pushes top=%0d second=%0d want 2 1", top, second);
                end
            end
        end
        n_checks++;
        if (top !== 64'd3 || top_type !== 2'd1 || count !== 5'd1 || empty !== 1'b0 || trap !== 4'd0) begin
            n_fail++;
            $display("FAIL add_final top=%0d type=%0d count=%0d empty=%b trap=%0d want 3 1 1 0 0",
                     top, top_type, count, empty, trap);
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) begin
            do_op((i == 17) ? 3'd2 : 3'd1, 64'(i), 2'd0, 2'd0);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL overflow_step%0d got %h want %h", i, obs_v, exp_v);
            end
            if (i == 15) begin
                n_checks++;
                if (full !== 1'b1 || top !== 64'd15 || trap !== 4'd0) begin
                    n_fail++;
                    $display("FAIL overflow_full full=%b top=%0d trap=%0d want 1 15 0", full, top, trap);
                end
            end
        end
        n_checks++;
        if (trap !== 4'd1 || count !== 5'd16 || top !== 64'd15) begin
            n_fail++;
            $display("FAIL overflow_trap trap=%0d count=%0d top=%0d want 1 16 15", trap, count, top);
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_underflow();
        logic [2:0] o_t [3] = '{3'd2, 3'd5, 3'd1};
        for (int i = 0; i < 3; i++) begin
            do_op(o_t[i], 64'd7, 2'd0, 2'd0);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL underflow_step%0d got %h want %h", i, obs_v, exp_v);
            end
            if (i == 0) begin
                n_checks++;
                if (trap !== 4'd2 || count !== 5'd0) begin
                    n_fail++;
                    $display("FAIL underflow_trap trap=%0d count=%0d want 2 0", trap, count);
                end
            end
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_mismatch();
        logic [2:0]  o_t  [3] = '{3'd1, 3'd1, 3'd4};
        logic [63:0] d_t  [3] = '{64'd5, 64'd7, 64'd12};
        logic [1:0]  dt_t [3] = '{2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 3; i++) begin
            do_op(o_t[i], d_t[i], dt_t[i], 2'd1);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL mismatch_step%0d got %h want %h", i, obs_v, exp_v);
            end
        end
        n_checks++;
        if (trap !== 4'd3 || count !== 5'd2 || top !== 64'd7 || second !== 64'd5) begin
            n_fail++;
            $display("FAIL mismatch_state trap=%0d count=%0d top=%0d second=%0d want 3 2 7 5",
                     trap, count, top, second);
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_unary_nop();
        logic [2:0]  o_t [5] = '{3'd1, 3'd3, 3'd6, 3'd7, 3'd0};
        logic [63:0] d_t [5] = '{64'd9, 64'hFFFF_FFFF, 64'd55, 64'd66, 64'd77};
        for (int i = 0; i < 5; i++) begin
            do_op(o_t[i], d_t[i], 2'd0, 2'd0);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL unary_step%0d got %h want %h", i, obs_v, exp_v);
            end
        end
        n_checks++;
        if (top !== 64'hFFFF_FFFF || count !== 5'd1) begin
            n_fail++;
            $display("FAIL unary_result top=%h count=%0d want ffffffff 1", top, count);
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_back_to_back();
        // Fill, collapse at full, then drain with DROPs to reach the RAM read path
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            if (i < 16) o = 3'd1;
            else if (i < 20) o = 3'd4;
            else o = 3'd2;
            do_op(o, 64'(32'h1000 + i), 2'(i % 2 == 0 ? 0 : 0), 2'd0);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_step%0d got %h want %h", i, obs_v, exp_v);
            end
            if (i == 16) begin
                n_checks++;
                if (full !== 1'b0 || count !== 5'd15) begin
                    n_fail++;
                    $display("FAIL binary_at_full full=%b count=%0d want 0 15", full, count);
                end
            end
        end
        do_op(3'd5, 64'd0, 2'd0, 2'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(3'd1, 64'(100 + i), 2'd3, 2'd0);
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL areset_push%0d got %h want %h", i, obs_v, exp_v);
            end
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || top !== 64'd0 || trap !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_immediate count=%0d empty=%b top=%0d trap=%0d want 0 1 0 0",
                     count, empty, top, trap);
        end
        cnt_m = 0; trap_m = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        do_op(3'd1, 64'd42, 2'd1, 2'd0);
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL areset_resume got %h want %h", obs_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_underflow();
        test_mismatch();
        test_unary_nop();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
